// File: rtl/alu_pkg.sv
// Shared ALU definitions: flag bit positions and the sequential adder state encoding.
package alu_pkg;

    localparam int unsigned FLAG_Z = 3;
    localparam int unsigned FLAG_N = 2;
    localparam int unsigned FLAG_C = 1;
    localparam int unsigned FLAG_V = 0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/fac.sv
// Single-bit full adder cell used to build ripple chains.
module fac (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/rca_slice.sv
// CHUNK-bit ripple-carry slice built from fac cells; also exposes the carry into its MSB.
module rca_slice #(
    parameter int unsigned CHUNK = 4
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] sum,
    output logic             cout,
    output logic             c_msb_in
);

    logic [CHUNK:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < CHUNK; i++) begin : g_bit
        fac u_fac (
            .a  (a[i]),
            .b  (b[i]),
            .ci (c[i]),
            .s  (sum[i]),
            .co (c[i+1])
        );
    end

    assign cout     = c[CHUNK];
    assign c_msb_in = c[CHUNK-1];

endmodule

// File: rtl/rca_seq.sv
// Multi-cycle ripple-carry adder/subtractor: one CHUNK-bit slice per clock, LSB slice first,
// with a start/busy/done handshake and Z/N/C/V flags registered on completion.
module rca_seq
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CHUNK = 4
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             start,
    input  logic             sub,
    input  logic             cin,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic [3:0]       flags
);

    localparam int unsigned NCHUNK = WIDTH / CHUNK;
    localparam int unsigned KW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [KW-1:0] KLAST = KW'(NCHUNK - 1);

    state_e           state_q, state_d;
    logic [KW-1:0]    k_q, k_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] part_q, part_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             carry_q, carry_d;
    logic [3:0]       flags_q, flags_d;

    logic [CHUNK-1:0] slice_sum;
    logic             slice_cout;
    logic             slice_c_msb;

    // Operands shift right each RUN cycle, so the active slice always sits in the low bits.
    rca_slice #(
        .CHUNK (CHUNK)
    ) u_slice (
        .a        (a_q[CHUNK-1:0]),
        .b        (b_q[CHUNK-1:0]),
        .cin      (carry_q),
        .sum      (slice_sum),
        .cout     (slice_cout),
        .c_msb_in (slice_c_msb)
    );

    always_comb begin
        state_d  = state_q;
        k_d      = k_q;
        a_d      = a_q;
        b_d      = b_q;
        part_d   = part_q;
        carry_d  = carry_q;
        result_d = result_q;
        flags_d  = flags_q;

        unique case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (start) begin
                    a_d     = operand_a;
                    b_d     = sub ? ~operand_b : operand_b;
                    carry_d = sub | cin;
                    part_d  = '0;
                    k_d     = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                a_d     = a_q >> CHUNK;
                b_d     = b_q >> CHUNK;
                // Slice sums enter at the top; after NCHUNK cycles the word is LSB-aligned.
                part_d  = part_q >> CHUNK;
                part_d[WIDTH-1 -: CHUNK] = slice_sum;
                carry_d = slice_cout;
                k_d     = k_q + 1'b1;
                if (k_q == KLAST) begin
                    state_d         = DONE;
                    result_d        = part_d;
                    flags_d[FLAG_Z] = ~|part_d;
                    flags_d[FLAG_N] = part_d[WIDTH-1];
                    flags_d[FLAG_C] = slice_cout;
                    flags_d[FLAG_V] = slice_c_msb ^ slice_cout;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q  <= IDLE;
            k_q      <= '0;
            a_q      <= '0;
            b_q      <= '0;
            part_q   <= '0;
            carry_q  <= 1'b0;
            result_q <= '0;
            flags_q  <= '0;
        end else begin
            state_q  <= state_d;
            k_q      <= k_d;
            a_q      <= a_d;
            b_q      <= b_d;
            part_q   <= part_d;
            carry_q  <= carry_d;
            result_q <= result_d;
            flags_q  <= flags_d;
        end
    end

    assign busy      = (state_q == RUN);
    assign done      = (state_q == DONE);
    assign result    = result_q;
    assign flags     = flags_q;
    assign carry_out = flags_q[FLAG_C];

endmodule

// File: tb/tb_rca_seq.sv
// Directed bench for rca_seq: CHUNK=4 main instance plus CHUNK=1/8/16 instances on shared inputs.
module tb_rca_seq;

    localparam int NINST = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        sub;
    logic        cin;
    logic [15:0] op_a;
    logic [15:0] op_b;

    logic        busy_w [NINST];
    logic        done_w [NINST];
    logic [15:0] res_w  [NINST];
    logic        co_w   [NINST];
    logic [3:0]  flg_w  [NINST];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    function automatic int chunk_of(input int i);
        return (i == 0) ? 4 : (i == 1) ? 1 : (i == 2) ? 8 : 16;
    endfunction

    for (genvar i = 0; i < NINST; i++) begin : g_dut
        localparam int CH = (i == 0) ? 4 : (i == 1) ? 1 : (i == 2) ? 8 : 16;
        rca_seq #(
            .WIDTH (16),
            .CHUNK (CH)
        ) u_dut (
            .CLK       (clk),
            .RST       (rst),
            .start     (start),
            .sub       (sub),
            .cin       (cin),
            .operand_a (op_a),
            .operand_b (op_b),
            .busy      (busy_w[i]),
            .done      (done_w[i]),
            .result    (res_w[i]),
            .carry_out (co_w[i]),
            .flags     (flg_w[i])
        );
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // One operation on all instances; checks latency, result and flags of each.
    task automatic run_op(input string tag, input logic s, input logic c,
                          input logic [15:0] a, input logic [15:0] b,
                          input logic [15:0] er, input logic [3:0] ef);
        int          lat [NINST];
        logic [15:0] gr  [NINST];
        logic [3:0]  gf  [NINST];
        logic        gc  [NINST];
        int          nbusy = 0;
        int          ndone = 0;
        for (int i = 0; i < NINST; i++) begin
            lat[i] = 0;
            gr[i]  = '0;
            gf[i]  = '0;
            gc[i]  = 1'b0;
        end
        @(negedge clk);
        start = 1'b1;
        sub   = s;
        cin   = c;
        op_a  = a;
        op_b  = b;
        @(negedge clk);
        start = 1'b0;
        op_a  = 16'hDEAD;
        op_b  = 16'hBEEF;
        for (int n = 1; n <= 24; n++) begin
            if (busy_w[0]) nbusy++;
            if (done_w[0]) ndone++;
            for (int i = 0; i < NINST; i++) begin
                if (done_w[i] && lat[i] == 0) begin
                    lat[i] = n;
                    gr[i]  = res_w[i];
                    gf[i]  = flg_w[i];
                    gc[i]  = co_w[i];
                end
            end
            @(negedge clk);
        end
        check($sformatf("%s busy_cycles", tag), nbusy, 4);
        check($sformatf("%s done_cycles", tag), ndone, 1);
        for (int i = 0; i < NINST; i++) begin
            check($sformatf("%s c%0d latency", tag, chunk_of(i)), lat[i], 16 / chunk_of(i) + 1);
            check($sformatf("%s c%0d result", tag, chunk_of(i)), gr[i], er);
            check($sformatf("%s c%0d flags", tag, chunk_of(i)), gf[i], ef);
            check($sformatf("%s c%0d carry_out", tag, chunk_of(i)), gc[i], ef[1]);
        end
    endtask

    initial begin
        logic [15:0] ra, rb, bb, er;
        logic        rs, rc, c0;
        logic [16:0] s17;
        logic [3:0]  ef;
        int          n;

        rst   = 1'b1;
        start = 1'b0;
        sub   = 1'b0;
        cin   = 1'b0;
        op_a  = '0;
        op_b  = '0;
        repeat (3) @(negedge clk);
        check("reset busy", busy_w[0], 0);
        check("reset done", done_w[0], 0);
        check("reset result", res_w[0], 0);
        check("reset flags", flg_w[0], 0);
        check("reset carry_out", co_w[0], 0);
        rst = 1'b0;

        run_op("add_cin", 1'b0, 1'b1, 16'h00FF, 16'h0000, 16'h0100, 4'b0000);
        run_op("add_ovf", 1'b0, 1'b0, 16'h7FFF, 16'h0001, 16'h8000, 4'b0101);
        run_op("add_wrap", 1'b0, 1'b0, 16'hFFFF, 16'h0001, 16'h0000, 4'b1010);
        run_op("add_plain", 1'b0, 1'b0, 16'h1000, 16'h2000, 16'h3000, 4'b0000);
        run_op("sub_eq", 1'b1, 1'b0, 16'h0005, 16'h0005, 16'h0000, 4'b1010);
        run_op("sub_ovf", 1'b1, 1'b0, 16'h8000, 16'h0001, 16'h7FFF, 4'b0011);
        run_op("sub_borrow", 1'b1, 1'b0, 16'h0000, 16'h0001, 16'hFFFF, 4'b0100);
        run_op("sub_cin_ign", 1'b1, 1'b1, 16'h0003, 16'h0001, 16'h0002, 4'b0010);

        // Start during RUN is ignored; start held in DONE is accepted back-to-back.
        @(negedge clk);
        start = 1'b1; sub = 1'b0; cin = 1'b0; op_a = 16'h0011; op_b = 16'h0022;
        @(negedge clk);
        start = 1'b0;
        check("b2b busy_run1", busy_w[0], 1);
        @(negedge clk);
        start = 1'b1; sub = 1'b1; op_a = 16'hFFFF; op_b = 16'hFFFF;
        @(negedge clk);
        start = 1'b0; sub = 1'b0;
        @(negedge clk);
        check("b2b done_early", done_w[0], 0);
        @(negedge clk);
        check("b2b done", done_w[0], 1);
        check("b2b busy_in_done", busy_w[0], 0);
        check("b2b first_result", res_w[0], 16'h0033);
        check("b2b first_flags", flg_w[0], 4'b0000);
        start = 1'b1; op_a = 16'h0100; op_b = 16'h0200;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        for (int i = 1; i <= 12 && n == 0; i++) begin
            if (done_w[0]) n = i;
            else @(negedge clk);
        end
        check("b2b second_latency", n, 5);
        check("b2b second_result", res_w[0], 16'h0300);
        check("b2b second_flags", flg_w[0], 4'b0000);
        repeat (20) @(negedge clk);

        // Reset in RUN cycle 3 discards the operation immediately.
        start = 1'b1; op_a = 16'h0F0F; op_b = 16'h0101;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rst_mid busy_before", busy_w[0], 1);
        #1 rst = 1'b1;
        #1;
        check("rst_mid busy", busy_w[0], 0);
        check("rst_mid done", done_w[0], 0);
        check("rst_mid result", res_w[0], 0);
        check("rst_mid flags", flg_w[0], 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        n = 0;
        repeat (10) begin
            if (done_w[0]) n++;
            @(negedge clk);
        end
        check("rst_mid no_done", n, 0);
        run_op("post_rst", 1'b0, 1'b0, 16'h1234, 16'h4321, 16'h5555, 4'b0000);

        // Random operands against a 17-bit reference sum.
        for (int t = 0; t < 150; t++) begin
            ra  = 16'($urandom);
            rb  = 16'($urandom);
            rs  = 1'($urandom);
            rc  = 1'($urandom);
            bb  = rs ? ~rb : rb;
            c0  = rs ? 1'b1 : rc;
            s17 = {1'b0, ra} + {1'b0, bb} + {16'b0, c0};
            er  = s17[15:0];
            ef  = {er == 16'h0, er[15], s17[16], (ra[15] == bb[15]) && (er[15] != ra[15])};
            run_op($sformatf("rnd%0d", t), rs, rc, ra, rb, er, ef);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
